coef_bank_memory: RTL and testbench
===================================

Name: coef_bank_memory

Overview:
- Responder side of the filter coefficient-memory interface: serves `coefaddress` reads from the lowpass FIR datapath and returns `coefdata` with a fixed 1-cycle latency.
- Holds two 128x18 coefficient banks, ping-pong style. The filter reads the active bank while a byte-stream loader fills the shadow bank.
- A swap request makes a newly loaded set active, so the filter never sees a half-written coefficient set.

Parameters:
- ADDR_W, 7, coefficient address width.
- DATA_W, 18, coefficient width, two's complement.
- NCOEF, 128, words per bank (2**ADDR_W).

Ports:
- clock  in  1  master clock, rising edge
- reset  in  1  asynchronous, active-low master reset
- coefaddress  in  7  read address from filter
- coefdata  out  18  registered read data
- load_start  in  1  pulse; begins a shadow-bank load
- load_byte  in  8  loader data byte
- load_valid  in  1  load_byte valid
- load_ready  out  1  loader accepts byte this cycle
- load_busy  out  1  loader not IDLE
- load_done  out  1  1-cycle pulse, shadow bank loaded and valid
- load_err  out  1  1-cycle pulse, load rejected
- swap_req  in  1  pulse; request bank swap
- swap_ack  out  1  1-cycle pulse, swap performed
- bank_sel  out  1  index of active bank
- coef_count  out  8  number of valid taps in active bank, 0..128

Behaviour:
- Reset (async assert, sync release):
  - Outputs: `coefdata`=0, `load_ready`=0, `load_busy`=0, `load_done`=0, `load_err`=0, `swap_ack`=0, `bank_sel`=0, `coef_count`=0.
  - Internal: shadow-valid flag=0, shadow count=0, FSM=IDLE.
  - Bank RAM contents are not reset.
- Read port:
  - `coefdata` is registered from the active bank at `coefaddress`.
  - Data appears the cycle after the address is presented.
  - Any address >= `coef_count` returns 0, so unused taps contribute nothing.
  - Reads are never stalled, including during a load.
- Loader FSM states: IDLE, COUNT, B0, B1, B2, CHK (CHK exists only with the feature), DONE.
  - IDLE: `load_ready`=0. On `load_start` -> COUNT, clear the shadow-valid flag.
  - COUNT: accept one byte N, the tap count; N=0 means 128, N>128 is impossible for 8 bits except 129..255.
    - N in 129..255 -> `load_err` pulse, -> IDLE.
    - Else latch N, word index=0, -> B0.
  - B0: accepted byte bits [1:0] become coefficient bits [17:16]; bits [7:2] are ignored. -> B1.
  - B1: byte becomes bits [15:8]. -> B2.
  - B2: byte becomes bits [7:0].
    - The shadow-bank write happens in the same cycle the byte is accepted, at word index.
    - Index increments. If index+1 == N, -> CHK or DONE; else -> B0.
  - DONE: `load_done`=1 for one cycle, set shadow-valid, shadow count=N. -> IDLE.
- Byte handshake:
  - A byte is accepted when `load_ready` && `load_valid`.
  - `load_ready`=1 in COUNT/B0/B1/B2/CHK. Throughput is one byte per cycle max.
  - Bubbles (`load_valid`=0) simply hold state.
- Boundary rules:
  - `load_start` while `load_busy`: ignored.
  - Bytes in IDLE: dropped.
- Swap:
  - A swap happens when `swap_req` is high in a cycle where FSM==IDLE and shadow-valid==1.
  - Next cycle: `bank_sel` toggles, `coef_count` = shadow count, shadow-valid clears, `swap_ack` pulses.
  - Reads presented from that cycle on use the new bank.
  - Otherwise `swap_req` is ignored, with no ack.
  - `swap_req` in the same cycle as DONE is ignored, because shadow-valid is not yet set.
- Reset mid-load aborts the load; the active bank stays readable but `coef_count`=0.

Optional Feature:
- Macro COEF_BANK_CHECKSUM_EN.
- Defined:
  - After the last B2, FSM enters CHK and accepts one byte.
  - That byte must equal the XOR of all bytes from the N byte through the last coefficient byte.
  - Match -> DONE.
  - Mismatch -> `load_err` pulse, shadow-valid stays 0, -> IDLE.
- Undefined: no CHK state, B2 goes straight to DONE, and `load_err` fires only on an illegal count.

Test Plan:
- Reset then read addr 0..5 -> `coefdata`=0 each, one cycle after the address; `bank_sel`=0, `coef_count`=0.
- Load N=3 with words 0x1FFFF, 0x00001, 0x20000 (bytes 03,01,FF,FF,00,00,01,02,00,00), then `swap_req`:
  - Expect `load_done` one cycle after the last byte, then `swap_ack`, `bank_sel`=1, `coef_count`=3.
  - Reads at addr 0/1/2/3 -> 0x1FFFF/0x00001/0x20000/0.
- Same load with `load_valid` toggling every other cycle -> identical bank contents; `load_ready` never high in IDLE.
- Count byte 0x90 -> `load_err` pulse, FSM back in IDLE; a following `swap_req` gives no ack and `bank_sel` is unchanged.
- `load_start` mid-load and `swap_req` while busy -> both ignored; continuous filter reads return old-bank data throughout the load.
- With COEF_BANK_CHECKSUM_EN:
  - N=1, bytes 01,00,12,34, checksum 0x27 -> `load_done`.
  - Checksum 0x26 -> `load_err`, and a following swap is ignored.

Source files
------------

// File: rtl/coef_bank_memory_if.sv
// Coefficient-memory bundle: filter read port, byte-stream loader handshake and bank-swap control.
// master = filter/loader side, slave = coefficient memory.
interface coef_bank_memory_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 18
);
  logic [ADDR_W-1:0] coefaddress;
  logic [DATA_W-1:0] coefdata;
  logic              load_start;
  logic [7:0]        load_byte;
  logic              load_valid;
  logic              load_ready;
  logic              load_busy;
  logic              load_done;
  logic              load_err;
  logic              swap_req;
  logic              swap_ack;
  logic              bank_sel;
  logic [7:0]        coef_count;

  modport master (
    output coefaddress, load_start, load_byte, load_valid, swap_req,
    input  coefdata, load_ready, load_busy, load_done, load_err, swap_ack, bank_sel, coef_count
  );

  modport slave (
    input  coefaddress, load_start, load_byte, load_valid, swap_req,
    output coefdata, load_ready, load_busy, load_done, load_err, swap_ack, bank_sel, coef_count
  );
endinterface

// File: rtl/coef_bank_memory.sv
// Ping-pong 2x128x18 coefficient store: 1-cycle registered reads from the active bank, byte loader fills the shadow bank.
// Loader accepts one byte per cycle on ready&&valid; COEF_BANK_CHECKSUM_EN adds a trailing XOR checksum byte.
module coef_bank_memory #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 18,
  parameter int NCOEF  = 128
) (
  input logic               clock,
  input logic               reset,
  coef_bank_memory_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_B0,
    S_B1,
    S_B2,
`ifdef COEF_BANK_CHECKSUM_EN
    S_CHK,
`endif
    S_DONE
  } state_t;

  // Reset asserts immediately but releases on a clock edge.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  logic [DATA_W-1:0] bank0_q [NCOEF];
  logic [DATA_W-1:0] bank1_q [NCOEF];

  state_t            state_q;
  logic              load_ready_q, load_busy_q, load_done_q, load_err_q;
  logic              swap_ack_q, bank_sel_q, shadow_vld_q;
  logic [7:0]        coef_count_q, shadow_cnt_q, ntap_q, idx_q;
  logic [1:0]        b0_q;
  logic [7:0]        b1_q;
  logic [DATA_W-1:0] coefdata_q, coefdata_d, wr_dat;
  logic [7:0]        addr_ext;
  logic              accept, swap_fire, wr_en;

  assign accept    = load_ready_q && bus.load_valid;
  assign swap_fire = (state_q == S_IDLE) && shadow_vld_q && bus.swap_req;
  assign wr_en     = (state_q == S_B2) && accept;
  assign wr_dat    = {b0_q, b1_q, bus.load_byte};

`ifdef COEF_BANK_CHECKSUM_EN
  logic [7:0] csum_q;

  // Running XOR from the count byte through the last coefficient byte.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n)      csum_q <= 8'd0;
    else if (accept) csum_q <= (state_q == S_COUNT) ? bus.load_byte : (csum_q ^ bus.load_byte);
  end
`endif

  // Shadow bank is always the one not selected for reading.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      if (bank_sel_q) bank0_q[idx_q[ADDR_W-1:0]] <= wr_dat;
      else            bank1_q[idx_q[ADDR_W-1:0]] <= wr_dat;
    end
  end

  assign addr_ext = 8'(bus.coefaddress);

  always_comb begin
    coefdata_d = '0;
    if (addr_ext < coef_count_q)
      coefdata_d = bank_sel_q ? bank1_q[bus.coefaddress] : bank0_q[bus.coefaddress];
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) coefdata_q <= '0;
    else        coefdata_q <= coefdata_d;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      load_ready_q <= 1'b0;
      load_busy_q  <= 1'b0;
      load_done_q  <= 1'b0;
      load_err_q   <= 1'b0;
      swap_ack_q   <= 1'b0;
      bank_sel_q   <= 1'b0;
      shadow_vld_q <= 1'b0;
      coef_count_q <= 8'd0;
      shadow_cnt_q <= 8'd0;
      ntap_q       <= 8'd0;
      idx_q        <= 8'd0;
      b0_q         <= 2'd0;
      b1_q         <= 8'd0;
    end else begin
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
      swap_ack_q  <= 1'b0;

      if (swap_fire) begin
        bank_sel_q   <= ~bank_sel_q;
        coef_count_q <= shadow_cnt_q;
        shadow_vld_q <= 1'b0;
        swap_ack_q   <= 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (bus.load_start) begin
            state_q      <= S_COUNT;
            shadow_vld_q <= 1'b0;
            load_ready_q <= 1'b1;
            load_busy_q  <= 1'b1;
          end
        end
        S_COUNT: begin
          if (accept) begin
            if (bus.load_byte > 8'd128) begin
              state_q      <= S_IDLE;
              load_err_q   <= 1'b1;
              load_ready_q <= 1'b0;
              load_busy_q  <= 1'b0;
            end else begin
              ntap_q  <= (bus.load_byte == 8'd0) ? 8'd128 : bus.load_byte;
              idx_q   <= 8'd0;
              state_q <= S_B0;
            end
          end
        end
        S_B0: begin
          if (accept) begin
            b0_q    <= bus.load_byte[1:0];
            state_q <= S_B1;
          end
        end
        S_B1: begin
          if (accept) begin
            b1_q    <= bus.load_byte;
            state_q <= S_B2;
          end
        end
        S_B2: begin
          if (accept) begin
            idx_q <= idx_q + 8'd1;
            if (idx_q + 8'd1 == ntap_q) begin
`ifdef COEF_BANK_CHECKSUM_EN
              state_q      <= S_CHK;
`else
              state_q      <= S_DONE;
              load_ready_q <= 1'b0;
              load_done_q  <= 1'b1;
`endif
            end else begin
              state_q <= S_B0;
            end
          end
        end
`ifdef COEF_BANK_CHECKSUM_EN
        S_CHK: begin
          if (accept) begin
            load_ready_q <= 1'b0;
            if (bus.load_byte == csum_q) begin
              state_q     <= S_DONE;
              load_done_q <= 1'b1;
            end else begin
              state_q     <= S_IDLE;
              load_err_q  <= 1'b1;
              load_busy_q <= 1'b0;
            end
          end
        end
`endif
        S_DONE: begin
          state_q      <= S_IDLE;
          load_busy_q  <= 1'b0;
          shadow_vld_q <= 1'b1;
          shadow_cnt_q <= ntap_q;
        end
        default: begin
          state_q      <= S_IDLE;
          load_ready_q <= 1'b0;
          load_busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.coefdata   = coefdata_q;
  assign bus.load_ready = load_ready_q;
  assign bus.load_busy  = load_busy_q;
  assign bus.load_done  = load_done_q;
  assign bus.load_err   = load_err_q;
  assign bus.swap_ack   = swap_ack_q;
  assign bus.bank_sel   = bank_sel_q;
  assign bus.coef_count = coef_count_q;

endmodule

// File: tb/tb_coef_bank_memory.sv
// Bench for coef_bank_memory: transaction-level model of both banks, random loads, gaps, swaps and reads.
module tb_coef_bank_memory;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  coef_bank_memory_if bus ();
  coef_bank_memory dut (.clock(clock), .reset(reset), .bus(bus));

  int checks = 0;
  int errors = 0;

  // Model: what each bank holds, which one is active, how many taps are live.
  logic [17:0] mdl_bank [2][128];
  logic        mdl_sel = 1'b0;
  int          mdl_count = 0;
  bit          mdl_sv = 1'b0;
  int          mdl_scnt = 0;

  logic [7:0]  stream_q [$];
  logic [17:0] words_q [$];
  int          load_n;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [17:0] exp_read(input logic [6:0] a);
    return (int'(a) < mdl_count) ? mdl_bank[mdl_sel][a] : 18'd0;
  endfunction

  task automatic make_stream(input logic [7:0] cb, input bit rnd, input bit junk);
    logic [7:0] x;
    logic [7:0] b;
    logic [17:0] w;
    load_n = (cb == 8'd0) ? 128 : ((cb > 8'd128) ? 0 : int'(cb));
    if (rnd) begin
      words_q.delete();
      for (int k = 0; k < load_n; k++) words_q.push_back(18'($urandom));
    end
    stream_q.delete();
    stream_q.push_back(cb);
    x = cb;
    for (int k = 0; k < load_n; k++) begin
      w = words_q[k];
      b = {junk ? 6'($urandom) : 6'd0, w[17:16]};
      stream_q.push_back(b);       x = x ^ b;
      stream_q.push_back(w[15:8]); x = x ^ w[15:8];
      stream_q.push_back(w[7:0]);  x = x ^ w[7:0];
    end
`ifdef COEF_BANK_CHECKSUM_EN
    if (load_n > 0) stream_q.push_back(x);
`endif
  endtask

  task automatic do_load(input bit gaps, input bit inject, input bit exp_ok, input string tag);
    int i;
    int cyc;
    bit v;
    logic [6:0] ra;
    logic [17:0] re;
    i = 0;
    cyc = 0;
    mdl_sv = 1'b0;
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
    checks++;
    if (bus.load_busy !== 1'b1) begin
      errors++; $display("FAIL %s busy_after_start got=%b want=1", tag, bus.load_busy);
    end
    while (i < stream_q.size() && cyc < 2000) begin
      checks++;
      if (bus.load_ready !== 1'b1) begin
        errors++; $display("FAIL %s ready_in_load byte=%0d got=%b want=1", tag, i, bus.load_ready);
      end
      v = gaps ? ((cyc % 2) == 1) : 1'b1;
      bus.load_valid = v;
      bus.load_byte  = v ? stream_q[i] : 8'($urandom);
      bus.load_start = inject && (i == 4);
      bus.swap_req   = inject && ($urandom_range(0, 1) == 1);
      ra = 7'($urandom);
      re = exp_read(ra);
      bus.coefaddress = ra;
      tick();
      if (v) i++;
      cyc++;
      checks++;
      if (bus.coefdata !== re || bus.swap_ack !== 1'b0 || bus.bank_sel !== mdl_sel) begin
        errors++;
        $display("FAIL %s read_during_load addr=%0d got=%h/ack%b/sel%b want=%h/ack0/sel%b",
                 tag, ra, bus.coefdata, bus.swap_ack, bus.bank_sel, re, mdl_sel);
      end
      if (i < stream_q.size()) begin
        checks++;
        if (bus.load_done !== 1'b0 || bus.load_err !== 1'b0) begin
          errors++; $display("FAIL %s early_pulse done=%b err=%b want=0/0", tag, bus.load_done, bus.load_err);
        end
      end
    end
    bus.load_valid = 1'b0;
    bus.load_start = 1'b0;
    bus.swap_req   = 1'b0;
    if (cyc >= 2000) begin
      checks++; errors++; $display("FAIL %s load_timeout accepted=%0d want=%0d", tag, i, stream_q.size());
    end
    checks++;
    if (bus.load_done !== exp_ok || bus.load_err !== !exp_ok || bus.load_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s end_pulse done=%b err=%b ready=%b want=%b/%b/0",
               tag, bus.load_done, bus.load_err, bus.load_ready, exp_ok, !exp_ok);
    end
    tick();
    checks++;
    if (bus.load_done !== 1'b0 || bus.load_err !== 1'b0 || bus.load_busy !== 1'b0 || bus.load_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s after_end done=%b err=%b busy=%b ready=%b want=0/0/0/0",
               tag, bus.load_done, bus.load_err, bus.load_busy, bus.load_ready);
    end
    if (exp_ok) begin
      mdl_sv = 1'b1;
      mdl_scnt = load_n;
      for (int k = 0; k < load_n; k++) mdl_bank[mdl_sel ? 0 : 1][k] = words_q[k];
    end
  endtask

  task automatic do_swap(input string tag);
    bit exp_ack;
    logic [6:0] ra;
    logic [17:0] re;
    exp_ack = mdl_sv;
    ra = 7'($urandom_range(0, 3));
    re = exp_read(ra);
    bus.coefaddress = ra;
    bus.swap_req = 1'b1;
    tick();
    bus.swap_req = 1'b0;
    checks++;
    if (bus.coefdata !== re) begin
      errors++; $display("FAIL %s read_at_swap addr=%0d got=%h want=%h", tag, ra, bus.coefdata, re);
    end
    if (exp_ack) begin
      mdl_sel = ~mdl_sel;
      mdl_count = mdl_scnt;
      mdl_sv = 1'b0;
    end
    checks++;
    if (bus.swap_ack !== exp_ack || bus.bank_sel !== mdl_sel || bus.coef_count !== 8'(mdl_count)) begin
      errors++;
      $display("FAIL %s swap ack=%b sel=%b cnt=%0d want=%b/%b/%0d",
               tag, bus.swap_ack, bus.bank_sel, bus.coef_count, exp_ack, mdl_sel, mdl_count);
    end
    ra = 7'($urandom_range(0, 3));
    re = exp_read(ra);
    bus.coefaddress = ra;
    tick();
    checks++;
    if (bus.swap_ack !== 1'b0 || bus.coefdata !== re) begin
      errors++; $display("FAIL %s after_swap ack=%b data=%h want=0/%h", tag, bus.swap_ack, bus.coefdata, re);
    end
  endtask

  task automatic sweep_reads(input string tag);
    int lim;
    logic [6:0] ra;
    logic [17:0] re;
    lim = (mdl_count + 2 > 128) ? 128 : mdl_count + 2;
    for (int a = 0; a < lim + 4; a++) begin
      ra = (a < lim) ? 7'(a) : 7'($urandom);
      re = exp_read(ra);
      bus.coefaddress = ra;
      tick();
      checks++;
      if (bus.coefdata !== re) begin
        errors++; $display("FAIL %s read addr=%0d got=%h want=%h", tag, ra, bus.coefdata, re);
      end
    end
  endtask

  task automatic test_reset();
    #3 reset = 1'b0;
    tick(); tick();
    checks++;
    if ({bus.coefdata, bus.load_ready, bus.load_busy, bus.load_done, bus.load_err,
         bus.swap_ack, bus.bank_sel, bus.coef_count} !== 33'd0) begin
      errors++; $display("FAIL reset_held outputs got=%h want=0", {bus.coefdata, bus.coef_count});
    end
    reset = 1'b1;
    repeat (4) tick();
    checks++;
    if ({bus.coefdata, bus.load_ready, bus.load_busy, bus.load_done, bus.load_err,
         bus.swap_ack, bus.bank_sel, bus.coef_count} !== 33'd0) begin
      errors++; $display("FAIL reset_released outputs got=%h want=0", {bus.coefdata, bus.coef_count});
    end
    for (int a = 0; a < 6; a++) begin
      bus.coefaddress = 7'(a);
      tick();
      checks++;
      if (bus.coefdata !== 18'd0) begin
        errors++; $display("FAIL reset_read addr=%0d got=%h want=0", a, bus.coefdata);
      end
    end
  endtask

  task automatic test_basic_load();
    logic [17:0] want [4];
    want[0] = 18'h1FFFF; want[1] = 18'h00001; want[2] = 18'h20000; want[3] = 18'h0;
    words_q = {18'h1FFFF, 18'h00001, 18'h20000};
    make_stream(8'd3, 1'b0, 1'b0);
    do_load(1'b0, 1'b0, 1'b1, "basic");
    do_swap("basic_swap");
    for (int a = 0; a < 4; a++) begin
      bus.coefaddress = 7'(a);
      tick();
      checks++;
      if (bus.coefdata !== want[a]) begin
        errors++; $display("FAIL basic_read addr=%0d got=%h want=%h", a, bus.coefdata, want[a]);
      end
    end
  endtask

  task automatic test_bubble_load();
    words_q = {18'h1FFFF, 18'h00001, 18'h20000};
    make_stream(8'd3, 1'b0, 1'b0);
    do_load(1'b1, 1'b0, 1'b1, "bubble");
    do_swap("bubble_swap");
    sweep_reads("bubble");
  endtask

  task automatic test_bad_count();
    make_stream(8'h90, 1'b0, 1'b0);
    do_load(1'b0, 1'b0, 1'b0, "badcnt");
    do_swap("badcnt_swap");
    sweep_reads("badcnt");
  endtask

  task automatic test_idle_bytes();
    for (int k = 0; k < 6; k++) begin
      bus.load_valid = 1'b1;
      bus.load_byte = 8'($urandom);
      tick();
      checks++;
      if (bus.load_ready !== 1'b0 || bus.load_busy !== 1'b0) begin
        errors++; $display("FAIL idle_bytes ready=%b busy=%b want=0/0", bus.load_ready, bus.load_busy);
      end
    end
    bus.load_valid = 1'b0;
    make_stream(8'd2, 1'b1, 1'b1);
    do_load(1'b0, 1'b0, 1'b1, "idle_then_load");
    do_swap("idle_swap");
    sweep_reads("idle");
  endtask

  task automatic test_busy_ignores();
    make_stream(8'd20, 1'b1, 1'b1);
    do_load(1'b1, 1'b1, 1'b1, "busy");
    do_swap("busy_swap");
    sweep_reads("busy");
  endtask

  task automatic test_random_loads();
    logic [7:0] cbs [4];
    cbs[0] = 8'd1; cbs[1] = 8'd0; cbs[2] = 8'd128; cbs[3] = 8'($urandom_range(2, 127));
    for (int k = 0; k < 4; k++) begin
      make_stream(cbs[k], 1'b1, 1'b1);
      do_load(1'($urandom_range(0, 1)), 1'b0, 1'b1, "rand");
      if (k != 2) do_swap("rand_swap");
      sweep_reads("rand");
    end
  endtask

`ifdef COEF_BANK_CHECKSUM_EN
  task automatic test_checksum();
    words_q = {18'h01234};
    load_n = 1;
    stream_q = {8'h01, 8'h00, 8'h12, 8'h34, 8'h27};
    do_load(1'b0, 1'b0, 1'b1, "csum_ok");
    do_swap("csum_ok_swap");
    sweep_reads("csum_ok");
    stream_q = {8'h01, 8'h00, 8'h12, 8'h34, 8'h26};
    do_load(1'b0, 1'b0, 1'b0, "csum_bad");
    do_swap("csum_bad_swap");
    sweep_reads("csum_bad");
  endtask
`endif

  task automatic test_reset_midload();
    make_stream(8'd10, 1'b1, 1'b1);
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
    bus.load_valid = 1'b1;
    for (int k = 0; k < 7; k++) begin
      bus.load_byte = stream_q[k];
      tick();
    end
    bus.load_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({bus.coef_count, bus.bank_sel, bus.load_busy, bus.load_ready, bus.load_done,
         bus.load_err, bus.swap_ack} !== 14'd0) begin
      errors++;
      $display("FAIL midload_reset cnt=%0d sel=%b busy=%b ready=%b want=0/0/0/0",
               bus.coef_count, bus.bank_sel, bus.load_busy, bus.load_ready);
    end
    tick(); tick();
    reset = 1'b1;
    repeat (4) tick();
    mdl_sel = 1'b0;
    mdl_count = 0;
    mdl_sv = 1'b0;
    do_swap("midload_swap");
    sweep_reads("midload");
    make_stream(8'd5, 1'b1, 1'b1);
    do_load(1'b1, 1'b0, 1'b1, "after_rst");
    do_swap("after_rst_swap");
    sweep_reads("after_rst");
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.coefaddress = '0;
    bus.load_start  = 1'b0;
    bus.load_byte   = 8'd0;
    bus.load_valid  = 1'b0;
    bus.swap_req    = 1'b0;
    test_reset();
    test_basic_load();
    test_bubble_load();
    test_bad_count();
    test_idle_bytes();
    test_busy_ignores();
    test_random_loads();
`ifdef COEF_BANK_CHECKSUM_EN
    test_checksum();
`endif
    test_reset_midload();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
